// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

   // Detector FSM states
   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      HUNT     = 2'd1,
      HIT      = 2'd2
   } state_t;

   localparam int MASK_W = 32;

   // Mask with the low 'len' bits set; callers truncate to their pattern width
   function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
      logic [MASK_W-1:0] m;
      if (len >= MASK_W)
         m = '1;
      else
         m = (MASK_W'(1) << len) - MASK_W'(1);
      return m;
   endfunction

endpackage

// File: rtl/seq_detect_hist.sv
// History shift register plus saturating count of bits accepted since the last restart.
module seq_detect_hist #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               shift_en,
   input  logic               in_bit,
   input  logic               restart,
   input  logic               clear,
   output logic [MAX_LEN-1:0] hist,
   output logic [LEN_W-1:0]   fill
);

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

   // Shift in accepted bits; clear wipes everything, restart only forgets the count
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         hist <= '0;
         fill <= '0;
      end else if (clear) begin
         hist <= '0;
         fill <= '0;
      end else begin
         if (shift_en)
            hist <= {hist[MAX_LEN-2:0], in_bit};
         if (restart)
            fill <= '0;
         else if (shift_en && fill != FILL_MAX)
            fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap control and saturating match counter.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               state;
   logic [MAX_LEN-1:0]   pat_q;
   logic [LEN_W-1:0]     len_q;
   logic                 ovl_q;

   logic [MAX_LEN-1:0]   hist;
   logic [LEN_W-1:0]     fill;

   logic [LEN_W-1:0]     len_clamped;
   logic [MAX_LEN-1:0]   mask;
   logic [MAX_LEN:0]     window;
   logic [LEN_W:0]       fill_p1;
   logic                 hit_now;

   // A cfg_load cycle discards its data bit and forgets all earlier bits
   seq_detect_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk      (clk),
      .aresetn  (aresetn),
      .shift_en (in_valid),
      .in_bit   (in_bit),
      .restart  (hit_now && !ovl_q),
      .clear    (cfg_load),
      .hist     (hist),
      .fill     (fill)
   );

   // Clamp length, build compare window including the incoming bit, detect a hit
   always_comb begin
      len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      mask        = MAX_LEN'(len_mask(MASK_W'(len_q)));
      window      = {hist, in_bit};
      fill_p1     = {1'b0, fill} + 1'b1;
      hit_now     = in_valid && !cfg_load && (state != DISABLED) &&
                    (fill_p1 >= {1'b0, len_q}) &&
                    ((window & {1'b0, mask}) == ({1'b0, pat_q} & {1'b0, mask}));
   end

   // Config latch and detector FSM with registered Moore outputs
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= DISABLED;
         pat_q <= '0;
         len_q <= '0;
         ovl_q <= 1'b0;
         match <= 1'b0;
         busy  <= 1'b0;
      end else if (cfg_load) begin
         pat_q <= cfg_pattern;
         len_q <= len_clamped;
         ovl_q <= cfg_overlap;
         match <= 1'b0;
         if (len_clamped == '0) begin
            state <= DISABLED;
            busy  <= 1'b0;
         end else begin
            state <= HUNT;
            busy  <= 1'b1;
         end
      end else if (state != DISABLED) begin
         busy <= 1'b1;
         if (hit_now) begin
            state <= HIT;
            match <= 1'b1;
         end else begin
            state <= HUNT;
            match <= 1'b0;
         end
      end
   end

   // Saturating match counter; a clear coinciding with a hit leaves one match counted
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         match_count <= '0;
      else if (cnt_clr)
         match_count <= hit_now ? CNT_W'(1) : '0;
      else if (hit_now && match_count != CNT_MAX)
         match_count <= match_count + 1'b1;
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: directed steps push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seq_detect_prog;

   logic       clk;
   logic       aresetn;
   logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;

   logic       match, busy;
   logic [7:0] match_count;
   logic       match2, busy2;
   logic [1:0] match_count2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       m;
      logic       b;
      logic [7:0] c;
      logic       k2;
      logic [1:0] c2;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .match(match), .match_count(match_count), .busy(busy)
   );

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .match(match2), .match_count(match_count2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per driven cycle, compared away from the active edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("match", 32'(match), 32'(mon_e.m));
         chk("busy", 32'(busy), 32'(mon_e.b));
         chk("match_count", 32'(match_count), 32'(mon_e.c));
         if (mon_e.k2) begin
            chk("match_count_sat", 32'(match_count2), 32'(mon_e.c2));
            chk("match_small", 32'(match2), 32'(mon_e.m));
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the next posedge
   task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                       input logic em, input logic eb, input int ec,
                       input logic k2 = 1'b0, input int ec2 = 0);
      exp_t e;
      in_valid = v;
      in_bit   = b;
      cfg_load = ld;
      cnt_clr  = clr;
      e.m  = em;
      e.b  = eb;
      e.c  = 8'(ec);
      e.k2 = k2;
      e.c2 = 2'(ec2);
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
   endtask

   initial begin
      aresetn  = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      cfg(8'h00, 4'd0, 1'b0);
      #12;
      chk("por_match", 32'(match), 0);
      chk("por_busy", 32'(busy), 0);
      chk("por_count", 32'(match_count), 0);
      @(negedge clk); #1;
      aresetn = 1'b1;

      // 1: reset mid-stream, then no detection until reconfigured
      cfg(8'b101, 4'd3, 1'b1);
      step(0,0,1,0, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(1,0,0,0, 0,1,0);
      aresetn = 1'b0;
      #1;
      chk("rst_match", 32'(match), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(match_count), 0);
      @(posedge clk); @(negedge clk); #1;
      aresetn = 1'b1;
      step(1,1,0,0, 0,0,0);
      step(1,0,0,0, 0,0,0);
      step(1,1,0,0, 0,0,0);

      // 2: overlapping 101
      cfg(8'b101, 4'd3, 1'b1);
      step(0,0,1,0, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(1,0,0,0, 0,1,0);
      step(1,1,0,0, 1,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 1,1,2);
      step(0,0,0,0, 0,1,2);

      // 3: non-overlapping 101
      cfg(8'b101, 4'd3, 1'b0);
      step(0,0,1,1, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(1,0,0,0, 0,1,0);
      step(1,1,0,0, 1,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 0,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 1,1,2);

      // 4: gaps and back-to-back 11
      cfg(8'b11, 4'd2, 1'b1);
      step(0,0,1,1, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(0,1,0,0, 0,1,0);
      step(1,1,0,0, 1,1,1);
      step(1,1,0,0, 1,1,2);
      step(1,1,0,0, 1,1,3);
      step(0,1,0,0, 0,1,3);

      // 5: reconfig mid-stream drops the load-cycle bit and old history
      cfg(8'b101, 4'd3, 1'b0);
      step(0,0,1,1, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(1,0,0,0, 0,1,0);
      cfg(8'b11, 4'd2, 1'b1);
      step(1,1,1,0, 0,1,0);
      step(1,1,0,0, 0,1,0);
      step(1,1,0,0, 1,1,1);
      step(0,0,0,0, 0,1,1);
      // length 0 disables
      cfg(8'b11, 4'd0, 1'b1);
      step(0,0,1,0, 0,0,1);
      step(1,1,0,0, 0,0,1);
      step(1,1,0,0, 0,0,1);
      step(1,1,0,0, 0,0,1);
      // length 15 clamps to 8
      cfg(8'hA5, 4'd15, 1'b0);
      step(0,0,1,0, 0,1,1);
      step(1,1,0,0, 0,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 0,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 0,1,1);
      step(1,0,0,0, 0,1,1);
      step(1,1,0,0, 1,1,2);
      step(0,0,0,0, 0,1,2);

      // 6: counter saturation (2-bit instance) and clear-with-hit
      cfg(8'b1, 4'd1, 1'b1);
      step(0,0,1,1, 0,1,0, 1,0);
      step(1,1,0,0, 1,1,1, 1,1);
      step(1,1,0,0, 1,1,2, 1,2);
      step(1,1,0,0, 1,1,3, 1,3);
      step(1,1,0,0, 1,1,4, 1,3);
      step(1,1,0,0, 1,1,5, 1,3);
      step(1,1,0,1, 1,1,1, 1,1);
      step(0,0,0,1, 0,1,0, 1,0);

      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
